// File: rtl/block_scheduler.sv
// GPU block scheduler: splits a kernel into fixed-size blocks and dispatches one block per
// cycle to enabled, free compute cores in round-robin order, with abort/drain and status.
module block_scheduler #(
    parameter int unsigned NUM_CORES         = 2,
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned TC_WIDTH          = 16,
    parameter int unsigned BID_WIDTH         = 16,
    localparam int unsigned CNT_WIDTH        = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [TC_WIDTH-1:0]            thread_count,
    input  logic [NUM_CORES-1:0]           core_enable,
    input  logic [NUM_CORES-1:0]           core_done,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES-1:0]           core_reset,
    output logic [NUM_CORES*BID_WIDTH-1:0] core_block_id,
    output logic [NUM_CORES*CNT_WIDTH-1:0] core_thread_count,
    output logic                           busy,
    output logic                           done,
    output logic                           aborted,
    output logic [BID_WIDTH-1:0]           blocks_dispatched,
    output logic [BID_WIDTH-1:0]           blocks_done
);

    localparam int unsigned LOG_TPB   = $clog2(THREADS_PER_BLOCK);
    localparam int unsigned TOT_WIDTH = BID_WIDTH + 1;
    localparam int unsigned SUM_WIDTH = TC_WIDTH + 1;
    localparam int unsigned RR_WIDTH  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [TC_WIDTH-1:0] TC_MASK = TC_WIDTH'(THREADS_PER_BLOCK - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [TOT_WIDTH-1:0]   total_q, total_d;
    logic [CNT_WIDTH-1:0]   tail_q, tail_d;
    logic [BID_WIDTH-1:0]   disp_q, disp_d;
    logic [BID_WIDTH-1:0]   fin_q, fin_d;
    logic [RR_WIDTH-1:0]    rr_q, rr_d;
    logic [NUM_CORES-1:0]   run_q, run_d;
    logic [BID_WIDTH-1:0]   bid_q [NUM_CORES];
    logic [BID_WIDTH-1:0]   bid_d [NUM_CORES];
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_CORES];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_CORES];
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;

    logic [NUM_CORES-1:0]   freed;
    logic [BID_WIDTH-1:0]   n_freed;
    logic                   pick_vld;
    logic [RR_WIDTH-1:0]    pick;
    logic [RR_WIDTH-1:0]    idx;
    logic                   more_blocks;
    logic                   last_blk;

    // Round-robin search uses the pre-edge run mask, so a core freed this edge waits a cycle.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = RR_WIDTH'((32'(rr_q) + k) % NUM_CORES);
            if (!pick_vld && core_enable[idx] && !run_q[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        freed   = core_done & run_q;
        n_freed = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            n_freed = n_freed + BID_WIDTH'(freed[i]);
        end
    end

    assign more_blocks = TOT_WIDTH'(disp_q) < total_q;
    assign last_blk    = (TOT_WIDTH'(disp_q) + TOT_WIDTH'(1)) == total_q;

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        tail_d    = tail_q;
        disp_d    = disp_q;
        fin_d     = fin_q + n_freed;
        rr_d      = rr_q;
        run_d     = run_q & ~freed;
        bid_d     = bid_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    total_d   = TOT_WIDTH'(({1'b0, thread_count}
                                + SUM_WIDTH'(THREADS_PER_BLOCK - 1)) >> LOG_TPB);
                    // Size of the final block: tc mod TPB, or a full block when it divides evenly.
                    tail_d    = (|(thread_count & TC_MASK)) ? CNT_WIDTH'(thread_count & TC_MASK)
                                                            : CNT_WIDTH'(THREADS_PER_BLOCK);
                    disp_d    = '0;
                    fin_d     = '0;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StDrain;
                    if (run_d == '0) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        aborted_d = 1'b1;
                    end
                end else begin
                    if (pick_vld && more_blocks) begin
                        run_d[pick] = 1'b1;
                        bid_d[pick] = disp_q;
                        cnt_d[pick] = last_blk ? tail_q : CNT_WIDTH'(THREADS_PER_BLOCK);
                        disp_d      = disp_q + BID_WIDTH'(1);
                        rr_d        = (pick == RR_WIDTH'(NUM_CORES - 1)) ? '0
                                                                         : pick + RR_WIDTH'(1);
                    end
                    if (TOT_WIDTH'(disp_d) == total_q && run_d == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (run_d == '0) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            total_q   <= '0;
            tail_q    <= CNT_WIDTH'(THREADS_PER_BLOCK);
            disp_q    <= '0;
            fin_q     <= '0;
            rr_q      <= '0;
            run_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                bid_q[i] <= '0;
                cnt_q[i] <= CNT_WIDTH'(THREADS_PER_BLOCK);
            end
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            tail_q    <= tail_d;
            disp_q    <= disp_d;
            fin_q     <= fin_d;
            rr_q      <= rr_d;
            run_q     <= run_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                bid_q[i] <= bid_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core_out
        assign core_block_id[g*BID_WIDTH +: BID_WIDTH]     = bid_q[g];
        assign core_thread_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

    assign core_start        = run_q;
    assign core_reset        = ~run_q;
    assign busy              = (state_q == StRun) || (state_q == StDrain);
    assign done              = done_q;
    assign aborted           = aborted_q;
    assign blocks_dispatched = disp_q;
    assign blocks_done       = fin_q;

endmodule

// File: tb/tb_block_scheduler.sv
// Bench for block_scheduler: directed scenarios plus random kernels, all outputs compared
// every cycle against a queue-free behavioural model of the scheduling rules.
module tb_block_scheduler;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TCW = 16;
    localparam int BW  = 16;
    localparam int CW  = 3;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [TCW-1:0] thread_count = '0;
    logic [NC-1:0]  core_enable = '1;
    logic [NC-1:0]  core_done = '0;
    logic [NC-1:0]  core_start;
    logic [NC-1:0]  core_reset;
    logic [NC*BW-1:0] core_block_id;
    logic [NC*CW-1:0] core_thread_count;
    logic           busy;
    logic           done;
    logic           aborted;
    logic [BW-1:0]  blocks_dispatched;
    logic [BW-1:0]  blocks_done;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;
    bit spurious_en = 0;
    int fixed_lat [NC];

    always #5 clk = ~clk;

    block_scheduler #(
        .NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .TC_WIDTH(TCW), .BID_WIDTH(BW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .thread_count(thread_count),
        .core_enable(core_enable), .core_done(core_done), .core_start(core_start),
        .core_reset(core_reset), .core_block_id(core_block_id),
        .core_thread_count(core_thread_count), .busy(busy), .done(done), .aborted(aborted),
        .blocks_dispatched(blocks_dispatched), .blocks_done(blocks_done)
    );

    // Behavioural model
    int m_state = S_IDLE;
    int m_tc = 0, m_total = 0, m_disp = 0, m_fin = 0, m_rr = 0;
    bit m_run [NC] = '{default: 0};
    int m_bid [NC] = '{default: 0};
    int m_cnt [NC] = '{default: TPB};
    bit m_done = 0, m_abt = 0;

    function automatic int inflight();
        int n = 0;
        for (int i = 0; i < NC; i++) n += m_run[i];
        return n;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_tc = 0; m_total = 0; m_disp = 0; m_fin = 0; m_rr = 0;
        m_done = 0; m_abt = 0;
        for (int i = 0; i < NC; i++) begin m_run[i] = 0; m_bid[i] = 0; m_cnt[i] = TPB; end
    endtask

    task automatic model_step();
        bit was_run [NC];
        bit found;
        int c;
        for (int i = 0; i < NC; i++) was_run[i] = m_run[i];
        for (int i = 0; i < NC; i++) begin
            if (core_done[i] && was_run[i]) begin m_run[i] = 0; m_fin++; end
        end
        case (m_state)
            S_IDLE, S_DONE: if (start) begin
                m_tc = int'(thread_count);
                m_total = (m_tc + TPB - 1) / TPB;
                m_disp = 0; m_fin = 0; m_done = 0; m_abt = 0; m_state = S_RUN;
            end
            S_RUN: if (abort) begin
                if (inflight() == 0) begin m_state = S_DONE; m_done = 1; m_abt = 1; end
                else m_state = S_DRAIN;
            end else begin
                found = 0;
                if (m_disp < m_total) begin
                    for (int k = 0; k < NC; k++) begin
                        c = (m_rr + k) % NC;
                        if (!found && core_enable[c] && !was_run[c]) begin
                            found = 1;
                            m_run[c] = 1;
                            m_bid[c] = m_disp;
                            m_cnt[c] = (m_disp == m_total - 1) ? m_tc - m_disp * TPB : TPB;
                            m_disp++;
                            m_rr = (c + 1) % NC;
                        end
                    end
                end
                if (m_disp == m_total && inflight() == 0) begin m_state = S_DONE; m_done = 1; end
            end
            S_DRAIN: if (inflight() == 0) begin m_state = S_DONE; m_done = 1; m_abt = 1; end
            default: ;
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // Core emulation: each running core raises core_done after a latency.
    int age [NC] = '{default: 0};
    int lat [NC] = '{default: 1};
    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (reset || !m_run[i]) begin
                age[i] = 0;
                core_done[i] = spurious_en && ($urandom_range(5) == 0);
            end else begin
                if (age[i] == 0) lat[i] = (fixed_lat[i] > 0) ? fixed_lat[i] : $urandom_range(1, 5);
                age[i]++;
                core_done[i] = (age[i] >= lat[i]);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NC-1:0] exp_cs;
        logic [NC-1:0] exp_cr;
        exp_cs = '0;
        for (int i = 0; i < NC; i++) exp_cs[i] = m_run[i];
        exp_cr = ~exp_cs;
        chk("core_start", core_start, exp_cs);
        chk("core_reset", core_reset, exp_cr);
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("core_block_id[%0d]", i), core_block_id[i*BW +: BW], m_bid[i]);
            chk($sformatf("core_thread_count[%0d]", i), core_thread_count[i*CW +: CW], m_cnt[i]);
        end
        chk("busy", busy, (m_state == S_RUN || m_state == S_DRAIN));
        chk("done", done, m_done);
        chk("aborted", aborted, m_abt);
        chk("blocks_dispatched", blocks_dispatched, m_disp);
        chk("blocks_done", blocks_done, m_fin);
        chk("inflight_invariant", blocks_dispatched - blocks_done, $countones(core_start));
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) compare_all();
    end

    task automatic launch(input int tc);
        @(negedge clk);
        start = 1'b1;
        thread_count = TCW'(tc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic edge_n();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk({name, "_completes"}, (done === 1'b1), 1);
    endtask

    initial begin
        int rises;
        bit saw_cs0;
        logic prev_cs1;
        fixed_lat = '{default: 0};

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_core_start", core_start, 0);
        chk("rst_core_reset", core_reset, 3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt0", core_thread_count[0 +: CW], 4);
        chk("rst_bid1", core_block_id[BW +: BW], 0);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1;

        // tc=10, both enabled, latency 3
        fixed_lat = '{3, 3};
        launch(10);
        edge_n();
        chk("t1_n1_cs", core_start, 2'b01);
        chk("t1_n1_bid0", core_block_id[0 +: BW], 0);
        chk("t1_n1_cnt0", core_thread_count[0 +: CW], 4);
        edge_n();
        chk("t1_n2_cs", core_start, 2'b11);
        chk("t1_n2_bid1", core_block_id[BW +: BW], 1);
        chk("t1_n2_cnt1", core_thread_count[CW +: CW], 4);
        edge_n();
        edge_n();
        chk("t1_n4_cs", core_start, 2'b10);
        chk("t1_n4_bdone", blocks_done, 1);
        edge_n();
        chk("t1_n5_cs", core_start, 2'b01);
        chk("t1_n5_bid0", core_block_id[0 +: BW], 2);
        chk("t1_n5_cnt0", core_thread_count[0 +: CW], 2);
        chk("t1_n5_bdone", blocks_done, 2);
        wait_done("t1");
        chk("t1_bdone", blocks_done, 3);
        chk("t1_aborted", aborted, 0);

        // tc=0
        launch(0);
        chk("t2_n0_done", done, 0);
        chk("t2_n0_busy", busy, 1);
        edge_n();
        chk("t2_n1_done", done, 1);
        chk("t2_n1_busy", busy, 0);
        chk("t2_n1_disp", blocks_dispatched, 0);
        chk("t2_n1_cs", core_start, 0);

        // tc=32 with abort one cycle after core1 starts
        launch(32);
        edge_n();
        edge_n();
        @(negedge clk);
        abort = 1'b1;
        edge_n();
        chk("t3_drain_busy", busy, 1);
        chk("t3_disp", blocks_dispatched, 2);
        @(negedge clk);
        abort = 1'b0;
        wait_done("t3");
        chk("t3_aborted", aborted, 1);
        chk("t3_bdone", blocks_done, 2);
        chk("t3_disp_final", blocks_dispatched, 2);

        // Only core1 enabled, tc=12
        core_enable = 2'b10;
        fixed_lat = '{2, 2};
        launch(12);
        rises = 0; saw_cs0 = 0; prev_cs1 = 1'b0;
        for (int n = 0; n < 100 && done !== 1'b1; n++) begin
            if (core_start[0]) saw_cs0 = 1;
            if (core_start[1] && !prev_cs1) rises++;
            prev_cs1 = core_start[1];
            @(negedge clk);
        end
        chk("t4_done", done, 1);
        chk("t4_core0_idle", saw_cs0, 0);
        chk("t4_core1_starts", rises, 3);
        chk("t4_bdone", blocks_done, 3);

        // Both cores complete on the same edge
        core_enable = 2'b11;
        fixed_lat = '{4, 3};
        launch(16);
        edge_n(); edge_n(); edge_n(); edge_n();
        chk("t5_n4_bdone", blocks_done, 0);
        edge_n();
        chk("t5_n5_bdone", blocks_done, 2);
        chk("t5_n5_cs", core_start, 2'b00);
        edge_n();
        chk("t5_n6_cs", core_start, 2'b01);
        chk("t5_n6_bid0", core_block_id[0 +: BW], 2);
        wait_done("t5");
        chk("t5_bdone", blocks_done, 4);

        // Asynchronous reset mid-run
        fixed_lat = '{0, 0};
        launch(32);
        edge_n(); edge_n(); edge_n();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_cs", core_start, 0);
        chk("t6_rst_cr", core_reset, 3);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_disp", blocks_dispatched, 0);
        chk("t6_rst_cnt1", core_thread_count[CW +: CW], 4);
        @(negedge clk);
        reset = 1'b0;
        launch(4);
        edge_n();
        chk("t6_cs", core_start, 2'b01);
        chk("t6_cnt0", core_thread_count[0 +: CW], 4);
        chk("t6_bid0", core_block_id[0 +: BW], 0);
        wait_done("t6");

        // Random kernels, enables, aborts and spurious core_done
        spurious_en = 1;
        repeat (4000) begin
            @(negedge clk);
            start = ($urandom_range(11) == 0);
            thread_count = TCW'($urandom_range(0, 40));
            abort = ($urandom_range(39) == 0);
            core_enable = NC'($urandom_range(0, 3));
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        core_enable = '1;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
